// File: rtl/bit_sampler_if.sv
// Serial line bundle between the RX pin side and the oversampling bit sampler.
// The master drives the raw line, and the slave returns one decided bit per bit period.
interface bit_sampler_if;
  logic raw_data;
  logic estimated_data;
  logic sample_clk;

  modport master (
    output raw_data,
    input  estimated_data,
    input  sample_clk
  );

  modport slave (
    input  raw_data,
    output estimated_data,
    output sample_clk
  );
endinterface

// File: rtl/bit_sampler.sv
// UART RX front end: synchronizes the oversampled serial line and majority-votes
// each OVERSAMPLE-cycle window into one registered bit, flagged by a one-cycle strobe.
module bit_sampler #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst,
  bit_sampler_if.slave bus
);

  localparam int PW = $clog2(OVERSAMPLE);
  localparam int CW = $clog2(OVERSAMPLE + 1);
  localparam int FW = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [FW-1:0]          r_fill;
  logic [PW-1:0]          r_phase;
  logic [CW-1:0]          r_ones;
  logic                   r_est;
  logic                   r_strobe;

  logic                   w_sample;
  logic                   w_active;
  logic                   w_last;
  logic [CW-1:0]          w_onesNext;
  logic                   w_estNext;

  assign w_sample   = r_sync[SYNC_STAGES-1];
  assign w_active   = (r_fill == FW'(SYNC_STAGES));
  assign w_last     = (r_phase == PW'(OVERSAMPLE - 1));
  assign w_onesNext = r_ones + CW'(w_sample);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.raw_data};
    end
  end

  // Windows only start once the synchronizer has shifted in the first captured raw sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fill <= '0;
    end else if (!w_active) begin
      r_fill <= r_fill + FW'(1);
    end
  end

  // A tie keeps the previous decision
  always_comb begin
    w_estNext = r_est;
    if (w_onesNext > CW'(OVERSAMPLE / 2)) begin
      w_estNext = 1'b1;
    end else if (w_onesNext < CW'(OVERSAMPLE / 2)) begin
      w_estNext = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase  <= '0;
      r_ones   <= '0;
      r_est    <= 1'b0;
      r_strobe <= 1'b0;
    end else if (w_active) begin
      r_phase <= r_phase + PW'(1);
      if (w_last) begin
        r_ones   <= '0;
        r_est    <= w_estNext;
        r_strobe <= 1'b1;
      end else begin
        r_ones   <= w_onesNext;
        r_strobe <= 1'b0;
      end
    end else begin
      r_strobe <= 1'b0;
    end
  end

  assign bus.estimated_data = r_est;
  assign bus.sample_clk     = r_strobe;

endmodule

// File: tb/tb_bit_sampler.sv
// Bench for bit_sampler: a raw-indexed majority model queues each expected decision
// with its strobe edge, and every edge is compared against the queue front.
module tb_bit_sampler;

  localparam int OS = 16;

  typedef struct {
    int   edgeNo;
    logic val;
  } expect_t;

  logic clk;
  logic rst;
  bit_sampler_if bus ();

  bit_sampler #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  expect_t expQ[$];
  int      edgeCnt;
  int      modelOnes;
  logic    modelDec;
  logic    expEst;
  int      checkCount;
  int      errorCount;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    expQ.delete();
    edgeCnt   = 0;
    modelOnes = 0;
    modelDec  = 1'b0;
    expEst    = 1'b0;
  endtask

  // Raw driven before edge e is captured at edge e; the window of captures
  // 16n+1..16n+16 is decided and strobed two edges later.
  task automatic applyStimulus(input logic b);
    expect_t e;
    int      capIdx;
    logic    dec;
    @(negedge clk);
    bus.raw_data = b;
    capIdx    = edgeCnt + 1;
    modelOnes = modelOnes + int'(b);
    if (capIdx % OS == 0) begin
      if (modelOnes > OS / 2)      dec = 1'b1;
      else if (modelOnes < OS / 2) dec = 1'b0;
      else                         dec = modelDec;
      modelDec  = dec;
      e.edgeNo  = capIdx + 2;
      e.val     = dec;
      expQ.push_back(e);
      modelOnes = 0;
    end
    @(posedge clk);
    edgeCnt++;
    #1;
    if (expQ.size() > 0 && expQ[0].edgeNo == edgeCnt) begin
      expEst = expQ[0].val;
      void'(expQ.pop_front());
      checkOutput($sformatf("strobe@%0d", edgeCnt), 32'(bus.sample_clk), 32'd1);
    end else begin
      checkOutput($sformatf("noStrobe@%0d", edgeCnt), 32'(bus.sample_clk), 32'd0);
    end
    checkOutput($sformatf("est@%0d", edgeCnt), 32'(bus.estimated_data), 32'(expEst));
  endtask

  task automatic applyRepeat(input logic b, input int n);
    for (int i = 0; i < n; i++) applyStimulus(b);
  endtask

  // Called just after a rising edge; asserts reset between edges and releases it
  // before the next falling edge so the following applyStimulus lands on edge 1.
  task automatic holdReset(input int cycles, input logic rawVal);
    #2 rst = 1'b0;
    bus.raw_data = rawVal;
    #1;
    checkOutput("rstImmEst", 32'(bus.estimated_data), 32'd0);
    checkOutput("rstImmStrobe", 32'(bus.sample_clk), 32'd0);
    resetModel();
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      checkOutput("rstHoldEst", 32'(bus.estimated_data), 32'd0);
      checkOutput("rstHoldStrobe", 32'(bus.sample_clk), 32'd0);
    end
    #2 rst = 1'b1;
  endtask

  initial begin
    checkCount   = 0;
    errorCount   = 0;
    bus.raw_data = 1'b0;
    rst          = 1'b1;
    resetModel();
    #1 rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      bus.raw_data = (i < 10) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      checkOutput("initRstEst", 32'(bus.estimated_data), 32'd0);
      checkOutput("initRstStrobe", 32'(bus.sample_clk), 32'd0);
    end
    #2 rst = 1'b1;

    $display("[TB] idle-low line");
    applyRepeat(1'b0, 150);

    $display("[TB] idle-high line");
    holdReset(3, 1'b1);
    applyRepeat(1'b1, 150);

    $display("[TB] glitchy high window");
    holdReset(3, 1'b0);
    applyRepeat(1'b1, 14);
    applyRepeat(1'b0, 2);
    applyRepeat(1'b1, 18);

    $display("[TB] multi-bit and ties");
    holdReset(3, 1'b1);
    applyRepeat(1'b0, 18);
    applyRepeat(1'b1, 16);
    applyRepeat(1'b0, 20);
    applyRepeat(1'b1, 8);
    applyRepeat(1'b0, 2);
    applyRepeat(1'b1, 16);
    applyRepeat(1'b1, 8);
    applyRepeat(1'b0, 8);
    applyRepeat(1'b0, 2);

    $display("[TB] random windows");
    for (int i = 0; i < 6 * OS; i++) applyStimulus(1'($urandom_range(0, 1)));

    $display("[TB] reset mid-window");
    applyRepeat(1'b1, 7);
    holdReset(2, 1'b1);
    for (int i = 0; i < 40; i++) applyStimulus(1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
